// File: rtl/seven_seg_capture.sv
// Receive side of an 8-digit multiplexed 7-segment display: samples the scanned
// anode/segment lines, decodes each settled digit and publishes the 32-bit word per frame.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segments_in,
    input  logic [7:0]  anodos_in,
    output logic [31:0] value_out,
    output logic        value_valid,
    output logic [7:0]  blank_mask,
    output logic [7:0]  err_mask
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);
    localparam cnt_t SETTLE_MAX  = cnt_t'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    logic [6:0]  seg_sync_q [SYNC_STAGES];
    logic [6:0]  seg_sync_d [SYNC_STAGES];
    logic [7:0]  an_sync_q  [SYNC_STAGES];
    logic [7:0]  an_sync_d  [SYNC_STAGES];

    logic [6:0]  seg_s;
    logic [7:0]  an_s;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [14:0] prev_q, prev_d;
    logic [31:0] slot_val_q, slot_val_d;
    logic [7:0]  slot_blank_q, slot_blank_d;
    logic [7:0]  slot_err_q, slot_err_d;
    logic [7:0]  seen_q, seen_d;
    logic        pend_q, pend_d;
    logic [31:0] value_out_q, value_out_d;
    logic        value_valid_q, value_valid_d;
    logic [7:0]  blank_mask_q, blank_mask_d;
    logic [7:0]  err_mask_q, err_mask_d;

    logic        an_valid;
    logic [2:0]  an_idx;
    logic [3:0]  n_zero;
    logic [3:0]  nibble;
    logic        is_blank;
    logic        is_err;
    logic        changed;
    logic        capture;
    logic [7:0]  idx_bit;

    always_comb begin
        seg_sync_d[0] = segments_in;
        an_sync_d[0]  = anodos_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            seg_sync_d[i] = seg_sync_q[i-1];
            an_sync_d[i]  = an_sync_q[i-1];
        end
    end

    assign seg_s = seg_sync_q[SYNC_STAGES-1];
    assign an_s  = an_sync_q[SYNC_STAGES-1];

    // Exactly one low anode selects a digit; anything else means no digit is lit.
    always_comb begin
        n_zero = 4'd0;
        an_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_s[i]) begin
                n_zero = n_zero + 4'd1;
                an_idx = 3'(i);
            end
        end
        an_valid = (n_zero == 4'd1);
    end

    always_comb begin
        nibble   = 4'hF;
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg_s)
            7'b0000001: nibble = 4'd0;
            7'b1001111: nibble = 4'd1;
            7'b0010010: nibble = 4'd2;
            7'b0000110: nibble = 4'd3;
            7'b1001100: nibble = 4'd4;
            7'b0100100: nibble = 4'd5;
            7'b0100000: nibble = 4'd6;
            7'b0001111: nibble = 4'd7;
            7'b0000000: nibble = 4'd8;
            7'b0000100: nibble = 4'd9;
            7'b1111111: is_blank = 1'b1;
            default:    is_err = 1'b1;
        endcase
    end

    assign changed = ({an_s, seg_s} != prev_q);
    assign idx_bit = 8'b1 << an_idx;

    always_comb begin
        state_d       = state_q;
        prev_d        = {an_s, seg_s};
        cnt_d         = cnt_q;
        capture       = 1'b0;
        slot_val_d    = slot_val_q;
        slot_blank_d  = slot_blank_q;
        slot_err_d    = slot_err_q;
        seen_d        = seen_q;
        pend_d        = 1'b0;
        value_out_d   = value_out_q;
        value_valid_d = 1'b0;
        blank_mask_d  = blank_mask_q;
        err_mask_d    = err_mask_q;

        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != SETTLE_MAX) begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        // Capture on the cycle the counter would reach SETTLE_CYCLES, so a dwell of
        // SETTLE_CYCLES+1 pin cycles is the shortest one that gets sampled.
        case (state_q)
            ST_WAIT: begin
                if (an_valid) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!an_valid) begin
                    state_d = ST_WAIT;
                end else if (!changed && cnt_q >= SETTLE_LAST) begin
                    capture = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (changed) state_d = an_valid ? ST_SETTLE : ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase

        if (pend_q) begin
            value_out_d   = slot_val_q;
            blank_mask_d  = slot_blank_q;
            err_mask_d    = slot_err_q;
            value_valid_d = 1'b1;
            seen_d        = 8'h00;
        end

        if (capture) begin
            slot_val_d[{an_idx, 2'b00} +: 4] = nibble;
            slot_blank_d[an_idx]             = is_blank;
            slot_err_d[an_idx]               = is_err;
            seen_d                           = seen_d | idx_bit;
            pend_d                           = ((seen_q | idx_bit) == 8'hFF);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= '1;
                an_sync_q[i]  <= '1;
            end
            state_q       <= ST_WAIT;
            cnt_q         <= '0;
            prev_q        <= '1;
            slot_val_q    <= '0;
            slot_blank_q  <= '0;
            slot_err_q    <= '0;
            seen_q        <= '0;
            pend_q        <= 1'b0;
            value_out_q   <= '0;
            value_valid_q <= 1'b0;
            blank_mask_q  <= '0;
            err_mask_q    <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= seg_sync_d[i];
                an_sync_q[i]  <= an_sync_d[i];
            end
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            slot_val_q    <= slot_val_d;
            slot_blank_q  <= slot_blank_d;
            slot_err_q    <= slot_err_d;
            seen_q        <= seen_d;
            pend_q        <= pend_d;
            value_out_q   <= value_out_d;
            value_valid_q <= value_valid_d;
            blank_mask_q  <= blank_mask_d;
            err_mask_q    <= err_mask_d;
        end
    end

    assign value_out   = value_out_q;
    assign value_valid = value_valid_q;
    assign blank_mask  = blank_mask_q;
    assign err_mask    = err_mask_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of full display scans plus
// hand-written sequences for invalid anodes, dwell boundary and mid-frame reset.
module tb_seven_seg_capture;

    logic        clock;
    logic        reset;
    logic [6:0]  segments_in;
    logic [7:0]  anodos_in;
    logic [31:0] value_out;
    logic        value_valid;
    logic [7:0]  blank_mask;
    logic [7:0]  err_mask;

    int total;
    int bad;
    int pulses;
    int p0;

    seven_seg_capture #(.SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .segments_in (segments_in),
        .anodos_in   (anodos_in),
        .value_out   (value_out),
        .value_valid (value_valid),
        .blank_mask  (blank_mask),
        .err_mask    (err_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial pulses = 0;
    always @(negedge clock) begin
        if (value_valid) pulses <= pulses + 1;
    end

    typedef struct {
        logic [55:0] segs;
        bit          rst_before;
        int          short_dig;
        int          exp_pulses;
        logic [31:0] exp_val;
        logic [7:0]  exp_blank;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'b0000001;
            4'd1: s = 7'b1001111;
            4'd2: s = 7'b0010010;
            4'd3: s = 7'b0000110;
            4'd4: s = 7'b1001100;
            4'd5: s = 7'b0100100;
            4'd6: s = 7'b0100000;
            4'd7: s = 7'b0001111;
            4'd8: s = 7'b0000000;
            default: s = 7'b0000100;
        endcase
        return s;
    endfunction

    function automatic logic [55:0] word_segs(input logic [31:0] w);
        logic [55:0] s;
        for (int k = 0; k < 8; k++) s[k*7 +: 7] = enc(w[k*4 +: 4]);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        anodos_in   = 8'hFF;
        segments_in = 7'h7F;
        reset       = 1'b1;
        @(negedge clock);
        reset       = 1'b0;
        @(negedge clock);
    endtask

    task automatic show(input int d, input logic [6:0] seg, input int dwell);
        anodos_in   = ~(8'b1 << d);
        segments_in = seg;
        repeat (dwell) @(negedge clock);
    endtask

    task automatic scan(input logic [55:0] segs, input int lo, input int hi,
                        input int short_dig, input int short_len);
        for (int d = lo; d <= hi; d++)
            show(d, segs[d*7 +: 7], (d == short_dig) ? short_len : 100);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        anodos_in   = 8'hFF;
        segments_in = 7'h7F;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_value", value_out, 32'h0);
        check("rst_valid", 32'(value_valid), 32'h0);
        check("rst_blank", 32'(blank_mask), 32'h0);
        check("rst_err", 32'(err_mask), 32'h0);

        vecs[0] = '{word_segs(32'h12345678), 1'b1, -1, 1, 32'h12345678, 8'h00, 8'h00};
        vecs[1] = '{word_segs(32'h12345678), 1'b0, -1, 1, 32'h12345678, 8'h00, 8'h00};
        vecs[2] = '{word_segs(32'h87654321), 1'b1,  3, 0, 32'h0,        8'h00, 8'h00};
        vecs[3] = '{word_segs(32'h87654321), 1'b0, -1, 1, 32'h87654321, 8'h00, 8'h00};
        vecs[4] = '{word_segs(32'h00345678), 1'b1, -1, 1, 32'hFF345678, 8'hC0, 8'h00};
        vecs[4].segs[42 +: 7] = 7'h7F;
        vecs[4].segs[49 +: 7] = 7'h7F;
        vecs[5] = '{word_segs(32'h99999999), 1'b1, -1, 1, 32'h9999999F, 8'h00, 8'h01};
        vecs[5].segs[0 +: 7] = 7'b0001000;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rst_before) do_reset();
            p0 = pulses;
            scan(vecs[v].segs, 0, 7, vecs[v].short_dig, 10);
            repeat (5) @(negedge clock);
            check($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].exp_pulses));
            if (vecs[v].exp_pulses != 0) begin
                check($sformatf("v%0d_value", v), value_out, vecs[v].exp_val);
                check($sformatf("v%0d_blank", v), 32'(blank_mask), 32'(vecs[v].exp_blank));
                check($sformatf("v%0d_err", v), 32'(err_mask), 32'(vecs[v].exp_err));
            end
        end

        // Invalid anode patterns between digits hold the FSM in WAIT.
        do_reset();
        p0 = pulses;
        scan(word_segs(32'h13572468), 0, 3, -1, 0);
        anodos_in   = 8'b11111100;
        segments_in = enc(4'd0);
        repeat (200) @(negedge clock);
        check("gap2_state", 32'(dut.state_q), 32'h0);
        check("gap2_seen", 32'(dut.seen_q), 32'h0F);
        anodos_in = 8'hFF;
        repeat (200) @(negedge clock);
        check("gapff_state", 32'(dut.state_q), 32'h0);
        check("gapff_seen", 32'(dut.seen_q), 32'h0F);
        check("gap_nopub", 32'(pulses - p0), 32'h0);
        scan(word_segs(32'h13572468), 4, 7, -1, 0);
        repeat (5) @(negedge clock);
        check("gap_pulses", 32'(pulses - p0), 32'h1);
        check("gap_value", value_out, 32'h13572468);

        // Dwell boundary: 16 pin cycles is rejected, 17 is sampled.
        do_reset();
        show(0, enc(4'd5), 16);
        anodos_in = 8'hFF;
        repeat (40) @(negedge clock);
        check("dwell16_seen", 32'(dut.seen_q), 32'h00);
        show(0, enc(4'd5), 17);
        anodos_in = 8'hFF;
        repeat (40) @(negedge clock);
        check("dwell17_seen", 32'(dut.seen_q), 32'h01);
        check("dwell17_slot", 32'(dut.slot_val_q[3:0]), 32'h5);

        // Reset after five captured digits discards the partial frame.
        p0 = pulses;
        scan(word_segs(32'h12345678), 0, 7, -1, 0);
        repeat (5) @(negedge clock);
        check("pre_pulses", 32'(pulses - p0), 32'h1);
        check("pre_value", value_out, 32'h12345678);
        p0 = pulses;
        scan(word_segs(32'h00000042), 0, 4, -1, 0);
        do_reset();
        repeat (30) @(negedge clock);
        check("mid_value", value_out, 32'h0);
        check("mid_blank", 32'(blank_mask), 32'h0);
        check("mid_err", 32'(err_mask), 32'h0);
        check("mid_seen", 32'(dut.seen_q), 32'h0);
        check("mid_nopub", 32'(pulses - p0), 32'h0);
        p0 = pulses;
        scan(word_segs(32'h00000042), 0, 7, -1, 0);
        repeat (5) @(negedge clock);
        check("post_pulses", 32'(pulses - p0), 32'h1);
        check("post_value", value_out, 32'h00000042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
